pipelined_adder: RTL

//   Parametrised, pipelined N-bit add/subtract unit with ADD/SUB/ADC/SBC modes, optional signed saturation and Z/N/C/V flags.

---
 rtl/pipelined_adder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/sub/adc/sbc unit with the carry chain split into
// SEG-bit segments, one segment resolved per pipeline stage. Optional signed
// saturation; Z/N/C/V flags; tag carried alongside each op. Valid/ready
// handshake with a single global advance: the whole pipe moves or holds.

module pipelined_adder #(
  parameter int N     = 24,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [1:0]       op,
  input  logic             c_in,
  input  logic             sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     R,
  output logic             Z_flag,
  output logic             N_flag,
  output logic             C_flag,
  output logic             V_flag,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = (N + SEG - 1) / SEG;
  // Width of the top segment; may be narrower than SEG.
  localparam int W_LAST = N - (STAGES - 1) * SEG;

  // Global advance: every stage moves together, bubbles included.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // vld_chain[k] is the valid bit entering stage k; vld_chain[STAGES] is the
  // output register's valid.
  logic [STAGES:1] vld_pipe;
  logic [STAGES:0] vld_chain;
  assign vld_chain = {vld_pipe, in_valid};
  assign out_valid = vld_chain[STAGES];

  // Operand conditioning: bit 0 of op selects subtract, bit 1 selects the
  // external carry.
  logic [N-1:0] b_eff;
  logic         cin0;
  assign b_eff = op[0] ? ~B : B;
  assign cin0  = op[1] ? c_in : op[0];

  // Valid shift register; in-flight ops vanish on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= vld_chain[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int W  = (k == STAGES - 1) ? W_LAST : SEG;
    // Upper B_eff bits not yet consumed when entering this stage.
    localparam int UW = N - LO;

    // acc: A with the already-resolved low segments replaced by sum bits.
    logic [N-1:0]     acc_in;
    logic [UW-1:0]    bx_in;
    logic             cy_in;
    logic             sat_in;
    logic [TAG_W-1:0] tag_in;
    logic [W-1:0]     sum;
    logic             cout;
    logic [N-1:0]     acc_nxt;

    if (k == 0) begin : g_src
      assign acc_in = A;
      assign bx_in  = b_eff;
      assign cy_in  = cin0;
      assign sat_in = sat;
      assign tag_in = in_tag;
    end else begin : g_src
      assign acc_in = g_stg[k-1].g_mid.acc_q;
      assign bx_in  = g_stg[k-1].g_mid.bx_q;
      assign cy_in  = g_stg[k-1].g_mid.cy_q;
      assign sat_in = g_stg[k-1].g_mid.sat_q;
      assign tag_in = g_stg[k-1].g_mid.tag_q;
    end

    pipelined_adder_seg #(.W(W)) u_seg (
      .a    (acc_in[LO +: W]),
      .b    (bx_in[W-1:0]),
      .cin  (cy_in),
      .sum  (sum),
      .cout (cout)
    );

    // Splice this stage's sum segment into the accumulator word.
    always_comb begin
      acc_nxt          = acc_in;
      acc_nxt[LO +: W] = sum;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [N-1:0]      acc_q;
      logic [UW-SEG-1:0] bx_q;
      logic              cy_q;
      logic              sat_q;
      logic [TAG_W-1:0]  tag_q;

      // Stage register; payload needs no reset since the valid bit gates it.
      always_ff @(posedge clk) begin
        if (adv) begin
          acc_q <= acc_nxt;
          bx_q  <= bx_in[UW-1:SEG];
          cy_q  <= cout;
          sat_q <= sat_in;
          tag_q <= tag_in;
        end
      end
    end else begin : g_fin
      // A's sign bit is still intact in acc_in; B_eff's sign is the top of bx_in.
      logic         a_sgn;
      logic         b_sgn;
      logic         v;
      logic [N-1:0] res;
      assign a_sgn = acc_in[N-1];
      assign b_sgn = bx_in[UW-1];
      assign v     = (a_sgn == b_sgn) && (acc_nxt[N-1] != a_sgn);
      assign res   = (sat_in && v) ? (a_sgn ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                                   : acc_nxt;

      // Output register: loads only real ops, holds across stalls and bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          R       <= '0;
          Z_flag  <= 1'b0;
          N_flag  <= 1'b0;
          C_flag  <= 1'b0;
          V_flag  <= 1'b0;
          out_tag <= '0;
        end else if (adv && vld_chain[k]) begin
          R       <= res;
          Z_flag  <= (res == '0);
          N_flag  <= res[N-1];
          C_flag  <= cout;
          V_flag  <= v;
          out_tag <= tag_in;
        end
      end
    end
  end

endmodule

// One carry-chain segment: W-bit add with carry in/out.
module pipelined_adder_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule
